// File: rtl/mod3_pkg.sv
// Shared constants and the residue update rule for the mod-3 stream controller.
package mod3_pkg;

    // Controller states (binary encoded, kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Legal residue values; 2'b11 is never produced
    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;

    // Appending one bit to a number MSB-first doubles it and adds the bit:
    // new residue = (2*r + b) mod 3, tabulated so no adder or divider is needed.
    function automatic logic [1:0] next_residue(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case ({r, b})
            3'b000:  n = R0;
            3'b001:  n = R1;
            3'b010:  n = R2;
            3'b011:  n = R0;
            3'b100:  n = R1;
            3'b101:  n = R2;
            default: n = R0;  // unreachable encoding folds back to a legal value
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod3_stream_ctrl_if.sv
// Word-in / result-out handshake bundle of the mod-3 stream controller.
interface mod3_stream_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             abort;
    logic             res_valid;
    logic             res_ready;
    logic             res_div;
    logic [1:0]       res_residue;
    logic             busy;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, abort, res_ready,
        input  in_ready, res_valid, res_div, res_residue, busy
    );

    // Controller side
    modport slave (
        input  in_valid, in_data, abort, res_ready,
        output in_ready, res_valid, res_div, res_residue, busy
    );
endinterface

// File: rtl/mod3_residue_step.sv
// Bit-serial mod-3 residue register: clears on clr, otherwise folds in one bit per enabled cycle.
module mod3_residue_step
    import mod3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] r
);

    logic [1:0] r_d;
    logic [1:0] r_q;

    // Next residue: clear wins over a shift step
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        r_d = r_q;
        if (clr) begin
            r_d = R0;
        end else if (en) begin
            r_d = next_residue(r_q, bit_in);
        end
    end

    // Residue register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (!reset) begin
            r_q <= R0;
        end else begin
            r_q <= r_d;
        end
    end

    assign r = r_q;

endmodule

// File: rtl/mod3_stream_ctrl.sv
// Accepts WIDTH-bit words, streams them MSB-first through the mod-3 residue step
// and presents the residue and divisibility flag on a held result handshake.
module mod3_stream_ctrl
    import mod3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    mod3_stream_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       in_ready;
    logic       accept;
    logic       res_valid;
    logic       last_bit;
    logic       step_clr;
    logic       step_en;
    logic [1:0] residue;

    // A finished result can be handed over and a new word taken in the same cycle
    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.res_ready);
    // abort blocks an accept in every state
    assign accept    = bus.in_valid & in_ready & ~bus.abort;
    assign res_valid = (state_q == ST_DONE);
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    // The residue starts fresh for each word and is discarded on abort
    assign step_clr  = accept | bus.abort;
    assign step_en   = (state_q == ST_SHIFT) & ~bus.abort;

    mod3_residue_step u_step (
        .clk    (clk),
        .reset  (reset),
        .clr    (step_clr),
        .en     (step_en),
        .bit_in (sreg_q[WIDTH-1]),
        .r      (residue)
    );

    // Sequencing: load on accept, shift WIDTH bits, hold the result until consumed
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A consumed result may be replaced by the next word without an idle cycle
        if (accept) begin
            state_d = ST_SHIFT;
            sreg_d  = bus.in_data;
            cnt_d   = '0;
        end

        // abort overrides both the accept and the completion
        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Controller registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the shift register is cleared on reset too; it is a handful of flops, not a memory array.
        if (!reset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result outputs are forced to zero whenever no result is offered
    assign bus.in_ready    = in_ready;
    assign bus.res_valid   = res_valid;
    assign bus.res_residue = res_valid ? residue : R0;
    assign bus.res_div     = res_valid & (residue == R0);
    assign bus.busy        = (state_q != ST_IDLE);

endmodule
